// File: rtl/routing_table_arbiter.sv
// Shared routing-table lookup engine: round-robin arbitration among input ports,
// one lookup per cycle with single-cycle latency, runtime-writable table.
module routing_table_arbiter #(
  parameter  int N             = 4,
  parameter  int PORTS         = 5,
  parameter  int DATA_WIDTH    = 8,
  parameter  int PhitPerFlit   = 2,
  parameter  int REQUEST_WIDTH = 2,
  localparam int FW            = PhitPerFlit * DATA_WIDTH,
  localparam int DW            = (N > 1) ? $clog2(N) : 1,
  localparam int PW            = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORTS-1:0]               req_valid,
  output logic [PORTS-1:0]               req_ready,
  input  logic [PORTS*FW-1:0]            HeadFlit,
  output logic [PORTS-1:0]               resp_valid,
  output logic [PORTS*REQUEST_WIDTH-1:0] RequestMessage,
  output logic [PORTS-1:0]               dest_error,
  input  logic                           cfg_we,
  input  logic [DW-1:0]                  cfg_addr,
  input  logic [REQUEST_WIDTH-1:0]       cfg_data
);

  logic [REQUEST_WIDTH-1:0] entry_q [N];
  logic [PW-1:0]            rr_q;
  logic [PW-1:0]            rr_next;
  logic [PW-1:0]            scan_idx;
  logic [PW-1:0]            grant_idx;
  logic                     grant_any;
  logic [DW-1:0]            grant_dest;
  logic                     dest_oob;
  logic [REQUEST_WIDTH-1:0] lookup_data;

  // Round-robin scan starting at rr_q; a table write blocks all grants that cycle.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    if (!rst && !cfg_we) begin
      for (int i = 0; i < PORTS; i++) begin
        scan_idx = PW'((int'(rr_q) + i) % PORTS);
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any           = 1'b1;
          grant_idx           = scan_idx;
          req_ready[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign rr_next = (grant_idx == PW'(PORTS - 1)) ? '0 : grant_idx + PW'(1);

  always_comb begin
    grant_dest = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (req_ready[p]) grant_dest = HeadFlit[p*FW +: DW];
    end
  end

  assign dest_oob    = (int'(grant_dest) >= N);
  assign lookup_data = dest_oob ? '0 : entry_q[grant_dest];

  // NOTE: the table is a register array cleared by reset, so each entry needs the reset branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) entry_q[i] <= '0;
    end else if (cfg_we && (int'(cfg_addr) < N)) begin
      entry_q[cfg_addr] <= cfg_data;
    end
  end

  // The lookup result is registered at the grant edge; reset drops anything in flight.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q           <= '0;
      resp_valid     <= '0;
      dest_error     <= '0;
      RequestMessage <= '0;
    end else begin
      resp_valid <= req_ready;
      dest_error <= '0;
      if (grant_any) rr_q <= rr_next;
      for (int p = 0; p < PORTS; p++) begin
        if (req_ready[p]) begin
          RequestMessage[p*REQUEST_WIDTH +: REQUEST_WIDTH] <= lookup_data;
          dest_error[p]                                    <= dest_oob;
        end
      end
    end
  end

endmodule
